vga_frame_receiver: RTL
=======================

VGA_FRAME_RECEIVER -- requirements
Module: vga_frame_receiver

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_SYNC, default 96, HS low width in pixel ticks.
REQ-003 SHALL have parameter H_BP, default 48, back porch in pixel ticks.
REQ-004 SHALL have parameter H_TOTAL, default 800, pixel ticks per line.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_SYNC, default 2, VS low width in lines.
REQ-007 SHALL have parameter V_BP, default 33, back porch in lines.
REQ-008 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-009 SHALL have port clk, input, 1, system clock; all logic on rising edge; one clock domain only.
REQ-010 SHALL have port clk_reset, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port pixel_tick, input, 1, one-clk strobe marking each pixel sample point.
REQ-012 SHALL have ports HS and VS, input, 1 each, active-low syncs from the VGA transmitter.
REQ-013 SHALL have ports RED, GREEN, BLUE, input, 4 each, pixel colour.
REQ-014 SHALL have port pixel_valid, output, 1, captured pixel is in the active area.
REQ-015 SHALL have ports pixel_x and pixel_y, output, 10 each, active-area coordinates.
REQ-016 SHALL have port pixel_rgb, output, 12, {RED,GREEN,BLUE} captured.
REQ-017 SHALL have port frame_start, output, 1, one-clk pulse when a frame is aligned.
REQ-018 SHALL have port locked, output, 1, receiver is tracking valid timing.
REQ-019 SHALL have port frame_count, output, 16, completed error-free frames.
REQ-020 SHALL have port error_count, output, 8, timing violations, saturating.

Function
REQ-021 SHALL sample HS, VS, RGB only on clk edges with pixel_tick=1; all other cycles hold sync history and counters.
REQ-022 SHALL detect HS fall (HS=0, previous sampled HS=1) and VS fall likewise, on ticks only.
REQ-023 SHALL implement FSM SEARCH -> ALIGN -> LOCKED; reset state SEARCH.
REQ-024 SEARCH: on VS fall go ALIGN; all other events ignored.
REQ-025 ALIGN: on next HS fall (same tick as VS fall allowed) go LOCKED, set h_cnt=0, v_cnt=0, pulse frame_start.
REQ-026 LOCKED: h_cnt increments per tick; on HS fall h_cnt=0 and v_cnt increments, wrapping to 0 after V_TOTAL-1.
REQ-027 LOCKED, HS fall with h_cnt != H_TOTAL-1: line error.
REQ-028 LOCKED, h_cnt reaches H_TOTAL-1 and next tick has no HS fall: line error (timeout).
REQ-029 LOCKED, HS fall that wraps v_cnt to 0: VS must have fallen since previous HS fall, else frame error; VS fall at any other line: frame error.
REQ-030 Good wrap: frame_start pulses, frame_count increments modulo 2^16.
REQ-031 Any error: go SEARCH same tick, error_count increments saturating at 255; simultaneous line and frame error count once.
REQ-032 pixel_valid=1 iff LOCKED and h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
REQ-033 pixel_x=h_cnt-(H_SYNC+H_BP), pixel_y=v_cnt-(V_SYNC+V_BP) when valid; 0 otherwise; pixel_rgb 0 when not valid.
REQ-034 All outputs registered; latency one clk after the sampling tick; pixel_valid and frame_start high exactly one clk per tick.
REQ-035 locked=1 in LOCKED only; deasserts the clk after the error tick.

Reset
REQ-036 clk_reset low SHALL asynchronously force SEARCH, all counters 0, sync history 1, all outputs 0, including mid-frame.
REQ-037 After release, no output activity until a VS fall then HS fall are sampled.

Verification
REQ-038 Reset, then ideal 640x480 stream, tick every 4th clk -> locked after first VS/HS fall; first pixel_valid at h_cnt 144, v_cnt 35 with x=0,y=0; last x=639,y=479.
REQ-039 Three ideal frames -> frame_count=2 after third alignment, error_count=0, exactly 307200 pixel_valid pulses per frame.
REQ-040 One line with HS fall at h_cnt 798 -> error_count=1, locked=0, relock at next VS fall.
REQ-041 Drive 256 consecutive line errors -> error_count stays 255.
REQ-042 Frame with VS fall at v_cnt 300 -> frame error, locked=0, frame_count unchanged.
REQ-043 clk_reset pulsed low mid-active-line -> all outputs 0 immediately, no pixel_valid until realignment.

Source files
------------

// File: rtl/vga_frame_receiver.sv
// VGA frame receiver: finds frame alignment from the HS/VS syncs, tracks the
// line/frame timing while locked, and emits active-area pixels with their
// coordinates. Any timing violation drops the receiver back to searching.
module vga_frame_receiver #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        clk_reset,
  input  logic        pixel_tick,
  input  logic        HS,
  input  logic        VS,
  input  logic [3:0]  RED,
  input  logic [3:0]  GREEN,
  input  logic [3:0]  BLUE,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [15:0] frame_count,
  output logic [7:0]  error_count
);

  localparam int unsigned HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned XW      = 10;
  localparam int unsigned YW      = 10;
  localparam int unsigned RGBW    = 12;
  localparam int unsigned FCW     = 16;
  localparam int unsigned ECW     = 8;
  localparam int unsigned H_FIRST = H_SYNC + H_BP;
  localparam int unsigned H_LAST  = H_FIRST + H_ACTIVE - 1;
  localparam int unsigned V_FIRST = V_SYNC + V_BP;
  localparam int unsigned V_LAST  = V_FIRST + V_ACTIVE - 1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic              vs_seen_q, vs_seen_d;
  logic [HCW-1:0]    h_cnt_q, h_cnt_d;
  logic [VCW-1:0]    v_cnt_q, v_cnt_d;
  logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [ECW-1:0]    err_cnt_q, err_cnt_d;
  logic              valid_q, valid_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [RGBW-1:0]   rgb_q, rgb_d;
  logic              fs_q, fs_d;
  logic              locked_q, locked_d;

  logic              hs_fall_c;
  logic              vs_fall_c;
  logic              h_last_c;
  logic              v_last_c;
  logic              line_err_c;
  logic              frame_err_c;
  logic              wrap_c;
  logic              align_c;
  logic              h_act_c;
  logic              v_act_c;

  // Sync edge detection, qualified by the pixel sample strobe
  assign hs_fall_c = pixel_tick & hs_prev_q & ~HS;
  assign vs_fall_c = pixel_tick & vs_prev_q & ~VS;
  assign h_last_c  = (h_cnt_q == HCW'(H_TOTAL - 1));
  assign v_last_c  = (v_cnt_q == VCW'(V_TOTAL - 1));

  // State, counters and output registers
  always_ff @(posedge clk or negedge clk_reset) begin
    if (!clk_reset) begin
      state_q     <= ST_SEARCH;
      hs_prev_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      vs_seen_q   <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      valid_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      rgb_q       <= '0;
      fs_q        <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      vs_seen_q   <= vs_seen_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rgb_q       <= rgb_d;
      fs_q        <= fs_d;
      locked_q    <= locked_d;
    end
  end

  // Next-state: alignment search, timing checks and pixel capture per tick
  always_comb begin
    state_d     = state_q;
    hs_prev_d   = hs_prev_q;
    vs_prev_d   = vs_prev_q;
    vs_seen_d   = vs_seen_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    valid_d     = 1'b0;
    x_d         = '0;
    y_d         = '0;
    rgb_d       = '0;
    fs_d        = 1'b0;
    line_err_c  = 1'b0;
    frame_err_c = 1'b0;
    wrap_c      = 1'b0;
    align_c     = 1'b0;
    h_act_c     = 1'b0;
    v_act_c     = 1'b0;

    if (pixel_tick) begin
      hs_prev_d = HS;
      vs_prev_d = VS;

      unique case (state_q)
        ST_SEARCH: begin
          // A VS fall arms alignment; a coincident HS fall aligns at once
          if (vs_fall_c) begin
            if (hs_fall_c) begin
              align_c = 1'b1;
            end else begin
              state_d = ST_ALIGN;
            end
          end
        end

        ST_ALIGN: begin
          if (hs_fall_c) begin
            align_c = 1'b1;
          end
        end

        ST_LOCKED: begin
          if (hs_fall_c) begin
            // Line boundary: length must be exact; wrap needs a VS fall in this line
            line_err_c = ~h_last_c;
            if (v_last_c) begin
              wrap_c      = 1'b1;
              frame_err_c = ~(vs_seen_q | vs_fall_c);
            end else begin
              frame_err_c = vs_fall_c;
            end
            h_cnt_d   = '0;
            v_cnt_d   = v_last_c ? '0 : v_cnt_q + VCW'(1);
            vs_seen_d = 1'b0;
          end else begin
            // Missing HS fall after the last tick of a line is a timeout
            line_err_c  = h_last_c;
            frame_err_c = vs_fall_c & ~v_last_c;
            h_cnt_d     = h_cnt_q + HCW'(1);
            if (vs_fall_c) begin
              vs_seen_d = 1'b1;
            end
          end

          if (line_err_c | frame_err_c) begin
            state_d   = ST_SEARCH;
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            vs_seen_d = 1'b0;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ECW'(1);
            end
          end else if (wrap_c) begin
            fs_d        = 1'b1;
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end

        default: begin
          state_d = ST_SEARCH;
        end
      endcase

      if (align_c) begin
        state_d   = ST_LOCKED;
        h_cnt_d   = '0;
        v_cnt_d   = '0;
        vs_seen_d = 1'b0;
        fs_d      = 1'b1;
      end

      // Active-area capture uses the position of this tick
      h_act_c = (h_cnt_d >= HCW'(H_FIRST)) && (h_cnt_d <= HCW'(H_LAST));
      v_act_c = (v_cnt_d >= VCW'(V_FIRST)) && (v_cnt_d <= VCW'(V_LAST));
      if ((state_d == ST_LOCKED) && h_act_c && v_act_c) begin
        valid_d = 1'b1;
        x_d     = XW'(h_cnt_d - HCW'(H_FIRST));
        y_d     = YW'(v_cnt_d - VCW'(V_FIRST));
        rgb_d   = {RED, GREEN, BLUE};
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  assign pixel_valid = valid_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign pixel_rgb   = rgb_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign frame_count = frame_cnt_q;
  assign error_count = err_cnt_q;

endmodule
